// File: rtl/board_pkg.sv
// Shared types and colour constants for the board renderer.
package board_pkg;

    localparam logic [2:0] COL_RED    = 3'b100;
    localparam logic [2:0] COL_WHITE  = 3'b111;
    localparam logic [2:0] COL_YELLOW = 3'b110;
    localparam logic [2:0] COL_BLUE   = 3'b001;
    localparam logic [2:0] COL_GREEN  = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        FIN
    } state_t;

    function automatic logic [2:0] tile_color(
        input logic mine,
        input logic flag,
        input logic step
    );
        logic [2:0] c;
        if (step && mine) c = COL_RED;
        else if (step)    c = COL_WHITE;
        else if (flag)    c = COL_YELLOW;
        else              c = COL_BLUE;
        return c;
    endfunction

endpackage

// File: rtl/board_renderer_if.sv
// Start/done handshake plus pixel write bus towards the frame-buffer adapter.
interface board_renderer_if;
    logic       start;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot;
    logic       busy;
    logic       done;

    modport master (
        input  start,
        output x, y, color, plot, busy, done
    );

    modport slave (
        output start,
        input  x, y, color, plot, busy, done
    );
endinterface

// File: rtl/board_renderer_tile_scan_counter.sv
// Nested pixel/tile scan counters; col/row tracked directly to avoid a divide.
module tile_scan_counter #(
    parameter int COLS   = 8,
    parameter int ROWS   = 8,
    parameter int TILE_W = 18,
    parameter int TILE_H = 13,
    localparam int PXW = (TILE_W > 1) ? $clog2(TILE_W) : 1,
    localparam int PYW = (TILE_H > 1) ? $clog2(TILE_H) : 1,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int TW  = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    output logic [PXW-1:0] px,
    output logic [PYW-1:0] py,
    output logic [CW-1:0]  col,
    output logic [RW-1:0]  row,
    output logic [TW-1:0]  tile,
    output logic           last
);

    logic last_px, last_py, last_col, last_row;

    assign last_px  = (px == PXW'(TILE_W - 1));
    assign last_py  = (py == PYW'(TILE_H - 1));
    assign last_col = (col == CW'(COLS - 1));
    assign last_row = (row == RW'(ROWS - 1));
    assign last     = last_px & last_py & last_col & last_row;

    always_ff @(posedge clk) begin
        if (reset) begin
            px   <= '0;
            py   <= '0;
            col  <= '0;
            row  <= '0;
            tile <= '0;
        end else if (en) begin
            if (!last_px) begin
                px <= px + PXW'(1);
            end else begin
                px <= '0;
                if (!last_py) begin
                    py <= py + PYW'(1);
                end else begin
                    py   <= '0;
                    tile <= last ? '0 : tile + TW'(1);
                    if (!last_col) begin
                        col <= col + CW'(1);
                    end else begin
                        col <= '0;
                        row <= last_row ? '0 : row + RW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/board_renderer.sv
// Draws a COLS x ROWS minesweeper board one pixel per cycle from a start-time map snapshot.
// Optional tile cursor outline enabled by defining BOARD_CURSOR_EN.
module board_renderer
    import board_pkg::*;
#(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int TILE_W  = 18,
    parameter int TILE_H  = 13,
    parameter int PITCH_X = 20,
    parameter int PITCH_Y = 15,
    parameter int X0      = 0,
    parameter int Y0      = 0,
    localparam int N   = COLS * ROWS,
    localparam int PXW = (TILE_W > 1) ? $clog2(TILE_W) : 1,
    localparam int PYW = (TILE_H > 1) ? $clog2(TILE_H) : 1,
    localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int TW  = (N > 1) ? $clog2(N) : 1,
    // one spare bit so out-of-range cursor indices are expressible
    localparam int KW  = TW + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N-1:0]           mine_map,
    input  logic [N-1:0]           flag_map,
    input  logic [N-1:0]           step_map,
`ifdef BOARD_CURSOR_EN
    input  logic [KW-1:0]          cursor_n,
`endif
    board_renderer_if.master       bus
);

    state_t state, state_n;

    logic [PXW-1:0] px;
    logic [PYW-1:0] py;
    logic [CW-1:0]  col;
    logic [RW-1:0]  row;
    logic [TW-1:0]  tile;
    logic           last;
    logic           last_q;
    logic           accept;
    logic           cnt_en;

    logic [N-1:0] mine_snap, flag_snap, step_snap;
    logic [N-1:0] mine_src, flag_src, step_src;
    logic [7:0]   x_n;
    logic [6:0]   y_n;
    logic [2:0]   c_n;

    tile_scan_counter #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .TILE_W (TILE_W),
        .TILE_H (TILE_H)
    ) u_scan (
        .clk   (clk),
        .reset (reset),
        .en    (cnt_en),
        .px    (px),
        .py    (py),
        .col   (col),
        .row   (row),
        .tile  (tile),
        .last  (last)
    );

    always_comb begin
        state_n = state;
        accept  = (state == IDLE) && bus.start;
        cnt_en  = accept || ((state == DRAW) && !last_q);
        unique case (state)
            IDLE:    if (bus.start) state_n = DRAW;
            DRAW:    if (last_q) state_n = FIN;
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            last_q <= cnt_en & last;
        end
    end

    // The pixel registered on the accept edge must use the live maps.
    assign mine_src = (state == IDLE) ? mine_map : mine_snap;
    assign flag_src = (state == IDLE) ? flag_map : flag_snap;
    assign step_src = (state == IDLE) ? step_map : step_snap;

`ifdef BOARD_CURSOR_EN
    logic [KW-1:0] cur_snap;
    logic [KW-1:0] cur_src;
    logic          outline;

    assign cur_src = (state == IDLE) ? cursor_n : cur_snap;
    assign outline = (px == '0) || (px == PXW'(TILE_W - 1)) ||
                     (py == '0) || (py == PYW'(TILE_H - 1));

    always_comb begin
        c_n = tile_color(mine_src[tile], flag_src[tile], step_src[tile]);
        if (outline && ({1'b0, tile} == cur_src)) c_n = COL_GREEN;
    end

    always_ff @(posedge clk) begin
        if (reset) cur_snap <= '0;
        else if (accept) cur_snap <= cursor_n;
    end
`else
    always_comb begin
        c_n = tile_color(mine_src[tile], flag_src[tile], step_src[tile]);
    end
`endif

    assign x_n = 8'(X0 + int'(col) * PITCH_X + int'(px));
    assign y_n = 7'(Y0 + int'(row) * PITCH_Y + int'(py));

    always_ff @(posedge clk) begin
        if (reset) begin
            mine_snap <= '0;
            flag_snap <= '0;
            step_snap <= '0;
        end else if (accept) begin
            mine_snap <= mine_map;
            flag_snap <= flag_map;
            step_snap <= step_map;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.x     <= '0;
            bus.y     <= '0;
            bus.color <= '0;
            bus.plot  <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
        end else begin
            bus.plot <= cnt_en;
            bus.busy <= cnt_en;
            bus.done <= (state == DRAW) && last_q;
            if (cnt_en) begin
                bus.x     <= x_n;
                bus.y     <= y_n;
                bus.color <= c_n;
            end
        end
    end

endmodule
